sc_lane_scroller: RTL and testbench

SC_LANE_SCROLLER -- requirements
Module: sc_lane_scroller

---
 rtl/sc_lane_scroller_if.sv | 35 +++
 rtl/sc_lane_scroller.sv | 128 ++++++++++++
 tb/tb_sc_lane_scroller.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_lane_scroller_if.sv
// Handshake bundle for the lane scroller: level/load/pause/mask in, lane state out.
interface sc_lane_scroller_if #(
    parameter int unsigned DATAWIDTH_BUS = 8
) ();
    logic [1:0]               SC_LANE_SCROLLER_NVL_IN;
    logic                     SC_LANE_SCROLLER_CN_IN;
    logic                     SC_LANE_SCROLLER_PAUSE_IN;
    logic [DATAWIDTH_BUS-1:0] SC_LANE_SCROLLER_MASK_IN;
    logic [DATAWIDTH_BUS-1:0] SC_LANE_SCROLLER_DATAPARALLEL_OUT;
    logic                     SC_LANE_SCROLLER_TICK_OUT;
    logic                     SC_LANE_SCROLLER_COLLISION_OUT;
    logic [1:0]               SC_LANE_SCROLLER_LEVEL_OUT;

    modport master (
        output SC_LANE_SCROLLER_NVL_IN,
        output SC_LANE_SCROLLER_CN_IN,
        output SC_LANE_SCROLLER_PAUSE_IN,
        output SC_LANE_SCROLLER_MASK_IN,
        input  SC_LANE_SCROLLER_DATAPARALLEL_OUT,
        input  SC_LANE_SCROLLER_TICK_OUT,
        input  SC_LANE_SCROLLER_COLLISION_OUT,
        input  SC_LANE_SCROLLER_LEVEL_OUT
    );

    modport slave (
        input  SC_LANE_SCROLLER_NVL_IN,
        input  SC_LANE_SCROLLER_CN_IN,
        input  SC_LANE_SCROLLER_PAUSE_IN,
        input  SC_LANE_SCROLLER_MASK_IN,
        output SC_LANE_SCROLLER_DATAPARALLEL_OUT,
        output SC_LANE_SCROLLER_TICK_OUT,
        output SC_LANE_SCROLLER_COLLISION_OUT,
        output SC_LANE_SCROLLER_LEVEL_OUT
    );
endinterface

// File: rtl/sc_lane_scroller.sv
// Scrolling obstacle lane: loads a per-level pattern and shifts/rotates it at a
// level-dependent rate, with pause, reload strobe and registered collision flag.
module sc_lane_scroller #(
    parameter int unsigned              DATAWIDTH_BUS   = 8,
    parameter logic [DATAWIDTH_BUS-1:0] NV_1_REG        = '0,
    parameter logic [DATAWIDTH_BUS-1:0] NV_2_REG        = '0,
    parameter logic [DATAWIDTH_BUS-1:0] NV_3_REG        = '0,
    parameter logic [DATAWIDTH_BUS-1:0] NV_4_REG        = '0,
    parameter int unsigned              DATAWIDTH_PRESC = 5,
    parameter int unsigned              VEL_SLOW        = 31,
    parameter int unsigned              VEL_NORM        = 15,
    parameter int unsigned              VEL_FAST        = 7,
    parameter bit                       DIR             = 1'b0,
    parameter bit                       WRAP            = 1'b1
) (
    input logic               SC_LANE_SCROLLER_CLOCK_50,
    input logic               SC_LANE_SCROLLER_RESET,
    sc_lane_scroller_if.slave bus
);
    localparam int unsigned W = DATAWIDTH_BUS;
    localparam int unsigned P = DATAWIDTH_PRESC;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StHold} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] lane_q, lane_d, shifted, pattern;
    logic [P-1:0] presc_q, presc_d, last_cnt;
    logic [1:0]   level_q, level_d;
    logic         tick_q, tick_d;
    logic         coll_q;

    always_comb begin
        case (level_q)
            2'd0:    pattern = NV_1_REG;
            2'd1:    pattern = NV_2_REG;
            2'd2:    pattern = NV_3_REG;
            default: pattern = NV_4_REG;
        endcase
    end

    // Terminal prescaler count; level 0 never reaches the move branch.
    always_comb begin
        case (level_q)
            2'd1:    last_cnt = P'(VEL_SLOW - 1);
            2'd2:    last_cnt = P'(VEL_NORM - 1);
            2'd3:    last_cnt = P'(VEL_FAST - 1);
            default: last_cnt = '0;
        endcase
    end

    always_comb begin
        if (!DIR) begin
            shifted = {lane_q[W-2:0], WRAP ? lane_q[W-1] : 1'b0};
        end else begin
            shifted = {WRAP ? lane_q[0] : 1'b0, lane_q[W-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        presc_d = presc_q;
        level_d = level_q;
        tick_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.SC_LANE_SCROLLER_CN_IN) begin
                    level_d = bus.SC_LANE_SCROLLER_NVL_IN;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                lane_d  = pattern;
                presc_d = '0;
                state_d = bus.SC_LANE_SCROLLER_PAUSE_IN ? StHold : StRun;
            end
            StRun: begin
                // Reload beats pause, and pause beats a coinciding move.
                if (bus.SC_LANE_SCROLLER_CN_IN) begin
                    level_d = bus.SC_LANE_SCROLLER_NVL_IN;
                    state_d = StLoad;
                end else if (bus.SC_LANE_SCROLLER_PAUSE_IN) begin
                    state_d = StHold;
                end else if (level_q != 2'd0) begin
                    if (presc_q == last_cnt) begin
                        presc_d = '0;
                        lane_d  = shifted;
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + P'(1);
                    end
                end
            end
            StHold: begin
                if (bus.SC_LANE_SCROLLER_CN_IN) begin
                    level_d = bus.SC_LANE_SCROLLER_NVL_IN;
                    state_d = StLoad;
                end else if (!bus.SC_LANE_SCROLLER_PAUSE_IN) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge SC_LANE_SCROLLER_CLOCK_50 or negedge SC_LANE_SCROLLER_RESET) begin
        if (!SC_LANE_SCROLLER_RESET) begin
            state_q <= StIdle;
            lane_q  <= '0;
            presc_q <= '0;
            level_q <= 2'd0;
            tick_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            presc_q <= presc_d;
            level_q <= level_d;
            tick_q  <= tick_d;
            coll_q  <= |(lane_q & bus.SC_LANE_SCROLLER_MASK_IN);
        end
    end

    assign bus.SC_LANE_SCROLLER_DATAPARALLEL_OUT = lane_q;
    assign bus.SC_LANE_SCROLLER_TICK_OUT         = tick_q;
    assign bus.SC_LANE_SCROLLER_COLLISION_OUT    = coll_q;
    assign bus.SC_LANE_SCROLLER_LEVEL_OUT        = level_q;
endmodule

// File: tb/tb_sc_lane_scroller.sv
// Random + directed bench for sc_lane_scroller: three variants (rotate left,
// rotate right, drain left) driven in lockstep against a behavioural lane model.
module tb_sc_lane_scroller;
    localparam int PhIdle = 0, PhLoad = 1, PhRun = 2, PhHold = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] nvl   = 2'd0;
    logic       cn    = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] mask  = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;

    sc_lane_scroller_if #(.DATAWIDTH_BUS(8)) bus0 ();
    sc_lane_scroller_if #(.DATAWIDTH_BUS(8)) bus1 ();
    sc_lane_scroller_if #(.DATAWIDTH_BUS(8)) bus2 ();

    assign bus0.SC_LANE_SCROLLER_NVL_IN = nvl;   assign bus1.SC_LANE_SCROLLER_NVL_IN = nvl;
    assign bus2.SC_LANE_SCROLLER_NVL_IN = nvl;
    assign bus0.SC_LANE_SCROLLER_CN_IN = cn;     assign bus1.SC_LANE_SCROLLER_CN_IN = cn;
    assign bus2.SC_LANE_SCROLLER_CN_IN = cn;
    assign bus0.SC_LANE_SCROLLER_PAUSE_IN = pause; assign bus1.SC_LANE_SCROLLER_PAUSE_IN = pause;
    assign bus2.SC_LANE_SCROLLER_PAUSE_IN = pause;
    assign bus0.SC_LANE_SCROLLER_MASK_IN = mask; assign bus1.SC_LANE_SCROLLER_MASK_IN = mask;
    assign bus2.SC_LANE_SCROLLER_MASK_IN = mask;

    logic [7:0] obs_lane [3];
    logic       obs_tick [3];
    logic       obs_coll [3];
    logic [1:0] obs_lvl  [3];
    assign obs_lane[0] = bus0.SC_LANE_SCROLLER_DATAPARALLEL_OUT;
    assign obs_lane[1] = bus1.SC_LANE_SCROLLER_DATAPARALLEL_OUT;
    assign obs_lane[2] = bus2.SC_LANE_SCROLLER_DATAPARALLEL_OUT;
    assign obs_tick[0] = bus0.SC_LANE_SCROLLER_TICK_OUT;
    assign obs_tick[1] = bus1.SC_LANE_SCROLLER_TICK_OUT;
    assign obs_tick[2] = bus2.SC_LANE_SCROLLER_TICK_OUT;
    assign obs_coll[0] = bus0.SC_LANE_SCROLLER_COLLISION_OUT;
    assign obs_coll[1] = bus1.SC_LANE_SCROLLER_COLLISION_OUT;
    assign obs_coll[2] = bus2.SC_LANE_SCROLLER_COLLISION_OUT;
    assign obs_lvl[0]  = bus0.SC_LANE_SCROLLER_LEVEL_OUT;
    assign obs_lvl[1]  = bus1.SC_LANE_SCROLLER_LEVEL_OUT;
    assign obs_lvl[2]  = bus2.SC_LANE_SCROLLER_LEVEL_OUT;

    sc_lane_scroller #(
        .DATAWIDTH_BUS(8), .NV_1_REG(8'h35), .NV_2_REG(8'hC1), .NV_3_REG(8'h96),
        .NV_4_REG(8'h18), .DATAWIDTH_PRESC(5), .VEL_SLOW(4), .VEL_NORM(2), .VEL_FAST(3),
        .DIR(1'b0), .WRAP(1'b1)
    ) dut0 (.SC_LANE_SCROLLER_CLOCK_50(clk), .SC_LANE_SCROLLER_RESET(rst_n), .bus(bus0));

    sc_lane_scroller #(
        .DATAWIDTH_BUS(8), .NV_1_REG(8'h35), .NV_2_REG(8'hC1), .NV_3_REG(8'h96),
        .NV_4_REG(8'h18), .DATAWIDTH_PRESC(5), .VEL_SLOW(4), .VEL_NORM(2), .VEL_FAST(3),
        .DIR(1'b1), .WRAP(1'b1)
    ) dut1 (.SC_LANE_SCROLLER_CLOCK_50(clk), .SC_LANE_SCROLLER_RESET(rst_n), .bus(bus1));

    sc_lane_scroller #(
        .DATAWIDTH_BUS(8), .NV_1_REG(8'h35), .NV_2_REG(8'hC1), .NV_3_REG(8'h96),
        .NV_4_REG(8'h18), .DATAWIDTH_PRESC(5), .VEL_SLOW(4), .VEL_NORM(2), .VEL_FAST(3),
        .DIR(1'b0), .WRAP(1'b0)
    ) dut2 (.SC_LANE_SCROLLER_CLOCK_50(clk), .SC_LANE_SCROLLER_RESET(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    // Reference model: phase, level, clocks counted toward the next move, lanes.
    int m_phase, m_level, m_elapsed;
    int m_lane [3];
    int m_coll [3];
    int m_tick;
    int dir_k  [3] = '{0, 1, 0};
    int wrap_k [3] = '{1, 1, 0};

    function automatic int pattern_of(input int lvl);
        case (lvl)
            0: return 'h35;
            1: return 'hC1;
            2: return 'h96;
            default: return 'h18;
        endcase
    endfunction

    function automatic int period_of(input int lvl);
        case (lvl)
            1: return 4;
            2: return 2;
            3: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int move(input int x, input int dir, input int wrap);
        if (dir == 0) return ((x * 2) % 256) + (wrap != 0 ? x / 128 : 0);
        return (x / 2) + (wrap != 0 ? (x % 2) * 128 : 0);
    endfunction

    task automatic model_reset();
        m_phase = PhIdle; m_level = 0; m_elapsed = 0; m_tick = 0;
        for (int k = 0; k < 3; k++) begin m_lane[k] = 0; m_coll[k] = 0; end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) m_coll[k] = ((m_lane[k] & int'(mask)) != 0) ? 1 : 0;
        m_tick = 0;
        case (m_phase)
            PhIdle: if (cn) begin m_level = int'(nvl); m_phase = PhLoad; end
            PhLoad: begin
                for (int k = 0; k < 3; k++) m_lane[k] = pattern_of(m_level);
                m_elapsed = 0;
                m_phase = pause ? PhHold : PhRun;
            end
            PhRun: begin
                if (cn) begin
                    m_level = int'(nvl); m_phase = PhLoad;
                end else if (pause) begin
                    m_phase = PhHold;
                end else if (m_level != 0) begin
                    m_elapsed++;
                    if (m_elapsed == period_of(m_level)) begin
                        m_elapsed = 0;
                        m_tick = 1;
                        for (int k = 0; k < 3; k++) m_lane[k] = move(m_lane[k], dir_k[k], wrap_k[k]);
                    end
                end
            end
            default: begin
                if (cn) begin m_level = int'(nvl); m_phase = PhLoad; end
                else if (!pause) m_phase = PhRun;
            end
        endcase
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("lane%0d", k), 32'(obs_lane[k]), 32'(m_lane[k]));
            check_eq($sformatf("tick%0d", k), 32'(obs_tick[k]), 32'(m_tick));
            check_eq($sformatf("coll%0d", k), 32'(obs_coll[k]), 32'(m_coll[k]));
            check_eq($sformatf("level%0d", k), 32'(obs_lvl[k]), 32'(m_level));
        end
    endtask

    task automatic do_cycle();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Entered at posedge+1; reset lands mid-cycle, well before the next edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic strobe(input logic [1:0] lvl);
        cn = 1'b1; nvl = lvl;
        do_cycle();
        cn = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 compare_all();
        @(posedge clk); #1;
        compare_all();
        rst_n = 1'b1;
        do_cycle(); do_cycle();

        // Level 1 from idle: load, then one move per 4 clocks.
        strobe(2'd1);
        do_cycle();
        check_eq("load_c1", 32'(obs_lane[0]), 32'h0C1);
        for (int i = 0; i < 4; i++) do_cycle();
        check_eq("rotl_83", 32'(obs_lane[0]), 32'h083);
        check_eq("rotl_tick", 32'(obs_tick[0]), 32'h1);
        check_eq("rotr_e0", 32'(obs_lane[1]), 32'h0E0);
        check_eq("drain_82", 32'(obs_lane[2]), 32'h082);
        for (int i = 0; i < 4; i++) do_cycle();
        check_eq("rotl_07", 32'(obs_lane[0]), 32'h007);
        check_eq("rotr_70", 32'(obs_lane[1]), 32'h070);
        check_eq("drain_04", 32'(obs_lane[2]), 32'h004);

        // Reload, with a strobe during LOAD that must be ignored, then pause.
        strobe(2'd1);
        cn = 1'b1; nvl = 2'd3;
        do_cycle();
        cn = 1'b0;
        check_eq("load_ignores_cn", 32'(obs_lvl[0]), 32'h1);
        do_cycle(); do_cycle();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) do_cycle();
        check_eq("pause_frozen", 32'(obs_lane[0]), 32'h0C1);
        pause = 1'b0;
        for (int i = 0; i < 8; i++) do_cycle();

        // Reload to level 2 in the exact cycle a move is due.
        begin
            int budget = 20;
            while (budget > 0 && !(m_phase == PhRun && m_level != 0 &&
                                   m_elapsed == period_of(m_level) - 1)) begin
                do_cycle();
                budget--;
            end
            check_eq("tick_wait_budget", 32'(budget > 0), 32'h1);
        end
        strobe(2'd2);
        check_eq("cn_beats_tick", 32'(obs_tick[0]), 32'h0);
        check_eq("level_2", 32'(obs_lvl[0]), 32'h2);
        for (int i = 0; i < 9; i++) do_cycle();

        // Drain the WRAP=0 lane fully; it must stay empty while ticking.
        for (int i = 0; i < 20; i++) do_cycle();
        check_eq("drain_empty", 32'(obs_lane[2]), 32'h0);

        // Level 0 is static; mask overlapping bit 0 flags a collision.
        strobe(2'd0);
        mask = 8'h01;
        for (int i = 0; i < 100; i++) do_cycle();
        check_eq("static_lane", 32'(obs_lane[0]), 32'h035);
        check_eq("static_coll", 32'(obs_coll[0]), 32'h1);
        mask = 8'h00;

        // Async reset mid-run; nothing moves until a new strobe.
        strobe(2'd3);
        for (int i = 0; i < 5; i++) do_cycle();
        async_reset();
        for (int i = 0; i < 6; i++) do_cycle();
        check_eq("post_reset_idle", 32'(obs_lane[0]), 32'h0);

        for (int i = 0; i < 600; i++) begin
            cn   = ($urandom_range(0, 9) == 0);
            nvl  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            mask = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 149) == 0) async_reset();
            else do_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
